uart_rx_fsm: RTL

Receive-side frame controller for the UART RX path. It detects the start bit and drives `count_EN` into the edge/bit counter. It consumes that counter's `edge_count`/`bit_count` to majority-sample each bit at mid-bit, deserialize data LSB-first, and check parity and stop bits. It delivers a validated byte with a one-cycle `Data_valid` strobe to the downstream consumer (synchronizer / register file).

---
 rtl/uart_rx_fsm.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/uart_rx_fsm.sv
// uart_rx_fsm: receive-side frame controller for the UART RX path.
// Detects the start bit, enables the external edge/bit counter, majority-samples
// each bit at mid-bit, deserializes LSB-first, checks parity and stop, and strobes
// a validated byte out.
//
// Ports:
//   CLK         oversampling clock
//   Reset       asynchronous, active-low reset
//   RX_IN       synchronized serial line, idle high
//   Prescale    oversampling ratio (>= 5), same value as the counter's
//   PAR_EN      parity bit present (captured at start-bit acceptance)
//   PAR_TYP     0 = even, 1 = odd (captured at start-bit acceptance)
//   edge_count  counter edge index within a bit, 1..Prescale
//   bit_count   counter frame bit index, 0 = start bit
//   count_EN    counter enable, high whenever not idle
//   P_DATA      last valid byte, updated only with Data_valid
//   Data_valid  one-cycle strobe for an error-free frame
//   par_err     one-cycle strobe at frame end on parity mismatch
//   stp_err     one-cycle strobe at frame end when the stop bit sampled 0
module uart_rx_fsm #(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  Reset,
    input  logic                  RX_IN,
    input  logic [4:0]            Prescale,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic [4:0]            edge_count,
    input  logic [3:0]            bit_count,
    output logic                  count_EN,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  Data_valid,
    output logic                  par_err,
    output logic                  stp_err
);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } state_e;

    localparam logic [3:0] LastDataBit = 4'(DATA_WIDTH);

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] sr_q, sr_d;
    logic                  par_en_q, par_en_d;
    logic                  par_typ_q, par_typ_d;
    logic                  par_flag_q, par_flag_d;
    logic [DATA_WIDTH-1:0] p_data_d;
    logic                  data_valid_d, par_err_d, stp_err_d;
    logic [2:0]            samp_q;

    logic [4:0] mid;
    logic       last;
    logic       sampled_bit;
    logic       exp_par;

    assign mid         = Prescale >> 1;
    assign last        = (edge_count == Prescale);
    assign sampled_bit = (samp_q[0] & samp_q[1]) | (samp_q[0] & samp_q[2]) |
                         (samp_q[1] & samp_q[2]);
    assign exp_par     = par_typ_q ? ~^sr_q : ^sr_q;
    assign count_EN    = (state_q != StIdle);

    // Three samples around mid-bit; all are settled well before the last edge.
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            samp_q <= 3'b111;
        end else begin
            if (edge_count == mid - 5'd1) samp_q[0] <= RX_IN;
            if (edge_count == mid)        samp_q[1] <= RX_IN;
            if (edge_count == mid + 5'd1) samp_q[2] <= RX_IN;
        end
    end

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state_q    <= StIdle;
            sr_q       <= '0;
            par_en_q   <= 1'b0;
            par_typ_q  <= 1'b0;
            par_flag_q <= 1'b0;
            P_DATA     <= '0;
            Data_valid <= 1'b0;
            par_err    <= 1'b0;
            stp_err    <= 1'b0;
        end else begin
            state_q    <= state_d;
            sr_q       <= sr_d;
            par_en_q   <= par_en_d;
            par_typ_q  <= par_typ_d;
            par_flag_q <= par_flag_d;
            P_DATA     <= p_data_d;
            Data_valid <= data_valid_d;
            par_err    <= par_err_d;
            stp_err    <= stp_err_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        sr_d         = sr_q;
        par_en_d     = par_en_q;
        par_typ_d    = par_typ_q;
        par_flag_d   = par_flag_q;
        p_data_d     = P_DATA;
        data_valid_d = 1'b0;
        par_err_d    = 1'b0;
        stp_err_d    = 1'b0;

        case (state_q)
            StIdle: begin
                // Frame configuration is frozen at the cycle the start edge is seen.
                par_en_d  = PAR_EN;
                par_typ_d = PAR_TYP;
                sr_d      = '0;
                if (!RX_IN) begin
                    state_d    = StStart;
                    par_flag_d = 1'b0;
                end
            end
            StStart: begin
                if (last) begin
                    state_d = sampled_bit ? StIdle : StData;
                end
            end
            StData: begin
                if (last) begin
                    sr_d = {sampled_bit, sr_q[DATA_WIDTH-1:1]};
                    if (bit_count == LastDataBit) begin
                        state_d = par_en_q ? StParity : StStop;
                    end
                end
            end
            StParity: begin
                if (last) begin
                    par_flag_d = (sampled_bit != exp_par);
                    state_d    = StStop;
                end
            end
            StStop: begin
                if (last) begin
                    stp_err_d = ~sampled_bit;
                    par_err_d = par_flag_q;
                    if (sampled_bit && !par_flag_q) begin
                        data_valid_d = 1'b1;
                        p_data_d     = sr_q;
                    end
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

endmodule
